uart_tx_frame: RTL and testbench

Parametrised UART transmitter that pops words from a first-word-fall-through FIFO and serialises them onto `tx`. The frame format is configurable: data width, parity enable, stop-bit count and bit order. Consecutive FIFO words go out back-to-back with no idle gap. It replaces the fixed 8-bit, always-parity, MSB-first transmitter on the `clk_3125_tx` domain and keeps the same FIFO-facing port names.

---
 rtl/uart_tx_frame.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: configurable UART serialiser fed by a FWFT FIFO.
// In: clk_3125_tx, rst_n, tx_start, parity_type, ft_out, ft_empty.
// Out: rd_en (pop strobe), tx (line), tx_done (last frame clock), busy.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 14,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 1
) (
  input  logic                 clk_3125_tx,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic                 parity_type,
  input  logic [DATA_BITS-1:0] ft_out,
  input  logic                 ft_empty,
  output logic                 rd_en,
  output logic                 tx,
  output logic                 tx_done,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_CLK  = CW'(CLKS_PER_BIT - 2);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_par
    $error("uart_tx_frame: PARITY_EN must be 0 or 1");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_bad_ord
    $error("uart_tx_frame: MSB_FIRST must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_d, rd_en_d, tx_done_d, busy_d;

  logic                 load_ok, load, cell_end, head;
  logic [DATA_BITS-1:0] shifted;

  assign load_ok  = tx_start && !ft_empty;
  assign cell_end = (clk_cnt_q == LAST_CLK);

  // Next data bit is always at the head; shreg moves it along.
  assign head    = (MSB_FIRST != 0) ? shreg_q[DATA_BITS-1]
                                    : shreg_q[0];
  assign shifted = (MSB_FIRST != 0) ? (shreg_q << 1)
                                    : (shreg_q >> 1);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    tx_d      = tx;
    rd_en_d   = 1'b0;
    tx_done_d = 1'b0;
    busy_d    = busy;
    load      = 1'b0;

    unique case (state_q)
      IDLE: begin
        load = load_ok;
      end
      START: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (cell_end) begin
          state_d   = DATA;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          tx_d      = head;
          shreg_d   = shifted;
        end
      end
      DATA: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (cell_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = head;
            shreg_d   = shifted;
          end
        end
      end
      PARITY: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (cell_end) begin
          state_d   = STOP;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          tx_d      = 1'b1;
        end
      end
      STOP: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        // Registered pulse, so raise it one clock early.
        tx_done_d = (bit_cnt_q == LAST_STOP) &&
                    (clk_cnt_q == PRE_CLK);
        if (cell_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            if (load_ok) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
      end
    endcase

    if (load) begin
      shreg_d   = ft_out;
      par_d     = (^ft_out) ^ parity_type;
      rd_en_d   = 1'b1;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      state_d   = START;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_3125_tx or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tx        <= 1'b1;
      rd_en     <= 1'b0;
      tx_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      tx        <= tx_d;
      rd_en     <= rd_en_d;
      tx_done   <= tx_done_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame.
// Three instances cover default, LSB-first and 7N2 frame formats.
module tb_uart_tx_frame;

  logic       clk;
  logic [2:0] rst_n;
  logic [2:0] tx_start;
  logic [2:0] parity_type;
  logic [2:0] ft_empty;
  logic [7:0] ft_out_a [3];
  logic [2:0] rd_en_w, tx_w, tx_done_w, busy_w;

  logic [7:0] mem [3][8];
  logic [3:0] wr [3];
  logic [3:0] rd [3] = '{4'd0, 4'd0, 4'd0};

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      nm;
    int         d;
    int         cpb;
    int         ncells;
    logic [7:0] word;
    logic       ptype;
    logic [0:11] cells;
  } vec_t;

  vec_t vecs [7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame u0 (
    .clk_3125_tx(clk), .rst_n(rst_n[0]),
    .tx_start(tx_start[0]), .parity_type(parity_type[0]),
    .ft_out(ft_out_a[0]), .ft_empty(ft_empty[0]),
    .rd_en(rd_en_w[0]), .tx(tx_w[0]),
    .tx_done(tx_done_w[0]), .busy(busy_w[0])
  );

  uart_tx_frame #(.MSB_FIRST(0)) u1 (
    .clk_3125_tx(clk), .rst_n(rst_n[1]),
    .tx_start(tx_start[1]), .parity_type(parity_type[1]),
    .ft_out(ft_out_a[1]), .ft_empty(ft_empty[1]),
    .rd_en(rd_en_w[1]), .tx(tx_w[1]),
    .tx_done(tx_done_w[1]), .busy(busy_w[1])
  );

  uart_tx_frame #(
    .CLKS_PER_BIT(4), .DATA_BITS(7),
    .PARITY_EN(0), .STOP_BITS(2)
  ) u2 (
    .clk_3125_tx(clk), .rst_n(rst_n[2]),
    .tx_start(tx_start[2]), .parity_type(parity_type[2]),
    .ft_out(ft_out_a[2][6:0]), .ft_empty(ft_empty[2]),
    .rd_en(rd_en_w[2]), .tx(tx_w[2]),
    .tx_done(tx_done_w[2]), .busy(busy_w[2])
  );

  // FWFT FIFO models: head visible while non-empty, pop on rd_en.
  always_comb begin
    for (int d = 0; d < 3; d++) begin
      ft_out_a[d] = mem[d][rd[d][2:0]];
      ft_empty[d] = (wr[d] == rd[d]);
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++)
      if (rd_en_w[d]) rd[d] <= rd[d] + 4'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [7:0] w);
    mem[d][wr[d][2:0]] = w;
    wr[d] = wr[d] + 4'd1;
  endtask

  task automatic flush(input int d);
    wr[d] = rd[d];
  endtask

  // Returns at the negedge where rd_en is first seen (frame cycle 1).
  task automatic wait_rd(input int d, input string nm,
                         output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rd_en_w[d]) ok = 1'b1;
    end
    chk({nm, "_rd_seen"}, int'(ok), 1);
  endtask

  // Called at frame cycle 1; returns at the frame's last cycle.
  task automatic check_frame(input int d, input int cpb,
                             input int ncells,
                             input logic [0:11] cells,
                             input string nm);
    int len, bad, rd_cnt, done_cnt, done_at, busy_lo, k;
    len = cpb * ncells;
    bad = 0; rd_cnt = 0; done_cnt = 0; done_at = 0; busy_lo = 0;
    for (int t = 1; t <= len; t++) begin
      if (t > 1) @(negedge clk);
      k = (t - 1) / cpb;
      if (tx_w[d] !== cells[k]) bad++;
      if (rd_en_w[d]) rd_cnt++;
      if (tx_done_w[d]) begin
        done_cnt++;
        done_at = t;
      end
      if (!busy_w[d]) busy_lo++;
      if ((t - 1) % cpb == cpb - 1) begin
        chk($sformatf("%s_cell%0d_exp%0b_badcyc", nm, k, cells[k]),
            bad, 0);
        bad = 0;
      end
    end
    chk({nm, "_rd_cnt"}, rd_cnt, 1);
    chk({nm, "_done_cnt"}, done_cnt, 1);
    chk({nm, "_done_at"}, done_at, len);
    chk({nm, "_busy_low"}, busy_lo, 0);
  endtask

  task automatic idle_check(input int d, input string nm);
    @(negedge clk);
    chk({nm, "_idle_tx"}, int'(tx_w[d]), 1);
    chk({nm, "_idle_busy"}, int'(busy_w[d]), 0);
    chk({nm, "_idle_done"}, int'(tx_done_w[d]), 0);
    chk({nm, "_idle_rd"}, int'(rd_en_w[d]), 0);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    push(v.d, v.word);
    parity_type[v.d] = v.ptype;
    tx_start[v.d] = 1'b1;
    wait_rd(v.d, v.nm, ok);
    if (ok) begin
      check_frame(v.d, v.cpb, v.ncells, v.cells, v.nm);
      idle_check(v.d, v.nm);
    end
    tx_start[v.d] = 1'b0;
    flush(v.d);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit ok;
    int rd_cnt, done_at, bad;

    vecs[0] = '{"a5_even", 0, 14, 11, 8'hA5, 1'b0, 12'b010100101010};
    vecs[1] = '{"01_odd_lsb", 1, 14, 11, 8'h01, 1'b1, 12'b010000000010};
    vecs[2] = '{"55_7n2", 2, 4, 10, 8'h55, 1'b0, 12'b010101011100};
    vecs[3] = '{"a5_odd", 0, 14, 11, 8'hA5, 1'b1, 12'b010100101110};
    vecs[4] = '{"00_even", 0, 14, 11, 8'h00, 1'b0, 12'b000000000010};
    vecs[5] = '{"0f_7n2", 2, 4, 10, 8'h0F, 1'b0, 12'b000011111100};
    vecs[6] = '{"c3_odd_lsb", 1, 14, 11, 8'hC3, 1'b1, 12'b011000011110};

    rst_n = 3'b000;
    tx_start = 3'b000;
    parity_type = 3'b000;
    for (int d = 0; d < 3; d++) begin
      wr[d] = 4'd0;
      for (int i = 0; i < 8; i++) mem[d][i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d_tx", d), int'(tx_w[d]), 1);
      chk($sformatf("rst%0d_rd", d), int'(rd_en_w[d]), 0);
      chk($sformatf("rst%0d_done", d), int'(tx_done_w[d]), 0);
      chk($sformatf("rst%0d_busy", d), int'(busy_w[d]), 0);
    end
    rst_n = 3'b111;

    // Empty FIFO with tx_start high: nothing happens.
    tx_start[0] = 1'b1;
    rd_cnt = 0; bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (rd_en_w[0]) rd_cnt++;
      if (tx_w[0] !== 1'b1 || busy_w[0]) bad++;
    end
    chk("empty_gate_rd", rd_cnt, 0);
    chk("empty_gate_line", bad, 0);
    tx_start[0] = 1'b0;

    // Word present but tx_start low: no load.
    push(0, 8'h77);
    rd_cnt = 0; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd_en_w[0]) rd_cnt++;
      if (tx_w[0] !== 1'b1 || busy_w[0]) bad++;
    end
    chk("nostart_gate_rd", rd_cnt, 0);
    chk("nostart_gate_line", bad, 0);
    flush(0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back 8'h12 then 8'h34.
    push(0, 8'h12);
    push(0, 8'h34);
    parity_type[0] = 1'b0;
    tx_start[0] = 1'b1;
    wait_rd(0, "b2b1", ok);
    if (ok) begin
      check_frame(0, 14, 11, 12'b000010010010, "b2b1");
      @(negedge clk);
      chk("b2b2_rd_adjacent", int'(rd_en_w[0]), 1);
      check_frame(0, 14, 11, 12'b000110100110, "b2b2");
      idle_check(0, "b2b");
    end
    tx_start[0] = 1'b0;
    flush(0);
    repeat (3) @(negedge clk);

    // tx_start dropped at cycle 50 with a second word waiting.
    push(0, 8'hA5);
    push(0, 8'h3C);
    tx_start[0] = 1'b1;
    wait_rd(0, "drop", ok);
    if (ok) begin
      rd_cnt = 0; done_at = 0; bad = 0;
      for (int t = 1; t <= 174; t++) begin
        if (t > 1) @(negedge clk);
        if (rd_en_w[0]) rd_cnt++;
        if (tx_done_w[0]) done_at = t;
        if (t > 154 && (busy_w[0] || tx_w[0] !== 1'b1)) bad++;
        if (t <= 154 && !busy_w[0]) bad++;
        if (t == 50) tx_start[0] = 1'b0;
      end
      chk("drop_rd_cnt", rd_cnt, 1);
      chk("drop_done_at", done_at, 154);
      chk("drop_busy_line", bad, 0);
      chk("drop_fifo_left", int'(ft_empty[0]), 0);
    end
    tx_start[0] = 1'b0;
    flush(0);
    repeat (3) @(negedge clk);

    // Reset asserted at cycle 70 of a frame.
    push(0, 8'hA5);
    tx_start[0] = 1'b1;
    wait_rd(0, "mrst", ok);
    if (ok) begin
      repeat (69) @(negedge clk);
      rst_n[0] = 1'b0;
      #1;
      chk("mrst_tx", int'(tx_w[0]), 1);
      chk("mrst_busy", int'(busy_w[0]), 0);
      chk("mrst_rd", int'(rd_en_w[0]), 0);
      chk("mrst_done", int'(tx_done_w[0]), 0);
      repeat (3) @(negedge clk);
      rst_n[0] = 1'b1;
      bad = 0;
      repeat (5) begin
        @(negedge clk);
        if (tx_w[0] !== 1'b1 || busy_w[0] || rd_en_w[0]) bad++;
      end
      chk("mrst_no_resume", bad, 0);
    end
    tx_start[0] = 1'b0;
    flush(0);
    run_vec('{"post_rst_5a", 0, 14, 11, 8'h5A, 1'b0,
              12'b001011010010});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
